add_shift_mult: RTL and testbench

Parametrised sequential add-shift multiplier: control FSM, iteration counter and datapath (accumulator, multiplicand register, multiplier/product shift register) in one block. It computes an N×N→2N-bit product in unsigned or two's-complement signed mode, selected per operation. A start/busy/done handshake lets the arithmetic unit issue back-to-back operations. It replaces the standalone control FSM, which had a fixed 32-bit count and no datapath or signed mode.

---
 rtl/add_shift_mult.sv | 161 ++++++++++++++++
 tb/tb_add_shift_mult.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_shift_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : add_shift_mult                                             |
// | Description : Sequential add-shift multiplier, N x N -> 2N bits, with    |
// |               per-operation unsigned / two's-complement signed mode.     |
// |               Control FSM, iteration counter and datapath in one block.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CLK      in   1    clock, rising edge                                  |
// |   RST      in   1    asynchronous active-high reset                      |
// |   ST       in   1    start request, sampled only while idle              |
// |   SIGNED   in   1    0 = unsigned, 1 = two's complement (sampled with ST)|
// |   MCAND    in   N    multiplicand (sampled with ST)                      |
// |   MPLIER   in   N    multiplier (sampled with ST)                        |
// |   BUSY     out  1    high whenever the FSM is not idle                   |
// |   DONE     out  1    one-cycle pulse when PRODUCT is updated             |
// |   PRODUCT  out  2N   result register, held until the next DONE          |
// +--------------------------------------------------------------------------+
module add_shift_mult #(
  parameter int N = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ST,
  input  logic           SIGNED,
  input  logic [N-1:0]   MCAND,
  input  logic [N-1:0]   MPLIER,
  output logic           BUSY,
  output logic           DONE,
  output logic [2*N-1:0] PRODUCT
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TEST  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_FIX   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N:0]       a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             done_q, done_d;

  // Operand magnitudes. The negation of the most negative value wraps back to
  // 2^(N-1), which is exactly the right magnitude when read as unsigned.
  logic [N-1:0]     mcand_mag;
  logic [N-1:0]     mplier_mag;
  logic [2*N-1:0]   raw_product;

  always_comb begin
    mcand_mag  = (SIGNED && MCAND[N-1])  ? -MCAND  : MCAND;
    mplier_mag = (SIGNED && MPLIER[N-1]) ? -MPLIER : MPLIER;
  end

  // A[N] is guaranteed zero once all iterations are done, so only the low
  // N bits of A form the upper product half.
  assign raw_product = {a_q[N-1:0], q_q};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ST) begin
          m_d     = mcand_mag;
          q_d     = mplier_mag;
          a_d     = '0;
          cnt_d   = '0;
          neg_d   = SIGNED & (MCAND[N-1] ^ MPLIER[N-1]);
          state_d = S_TEST;
        end
      end

      S_TEST: begin
        if (cnt_q == CW'(N)) begin
          state_d = S_FIX;
        end else if (q_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end

      S_ADD: begin
        a_d     = a_q + {1'b0, m_q};
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        // Logical right shift of the {A,Q} pair: A[0] falls into Q[N-1].
        a_d     = {1'b0, a_q[N:1]};
        q_d     = {a_q[0], q_q[N-1:1]};
        cnt_d   = cnt_q + CW'(1);
        state_d = S_TEST;
      end

      S_FIX: begin
        product_d = neg_q ? -raw_product : raw_product;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: all taken from registered state
  // --------------------------------------------------------------------------
  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = done_q;
  assign PRODUCT = product_q;

endmodule
`default_nettype wire

// File: tb/tb_add_shift_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_add_shift_mult                                          |
// | Description : Self-checking bench for add_shift_mult at N=8 and N=32.    |
// |               Directed vector table, hand-written held-start and reset   |
// |               sequences, randomised operands against a reference model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_add_shift_mult;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        st8 = 1'b0, s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        st32 = 1'b0, s32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [63:0] prod32;

  always #5 CLK = ~CLK;

  add_shift_mult #(.N(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .ST(st8), .SIGNED(s8), .MCAND(a8), .MPLIER(b8),
    .BUSY(busy8), .DONE(done8), .PRODUCT(prod8)
  );

  add_shift_mult #(.N(32)) u_dut32 (
    .CLK(CLK), .RST(RST), .ST(st32), .SIGNED(s32), .MCAND(a32), .MPLIER(b32),
    .BUSY(busy32), .DONE(done32), .PRODUCT(prod32)
  );

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          start;
  } sb_t;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  sb_t q8[$];
  sb_t q32[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: exact product from the simulator's own arithmetic.
  function automatic logic [63:0] ref_prod(input bit w32, input bit s,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xa, xb, p;
    if (w32) begin
      xa = s ? {{32{a[31]}}, a} : {32'b0, a};
      xb = s ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      return p;
    end else begin
      xa = s ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
      xb = s ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
      p  = xa * xb;
      return p & 64'hFFFF;
    end
  endfunction

  // Reference latency: 2N + popcount(multiplier magnitude) + 2.
  function automatic int ref_lat(input bit w32, input bit s, input logic [31:0] b);
    logic [31:0] mag;
    if (w32) begin
      mag = (s && b[31]) ? -b : b;
      return 66 + $countones(mag);
    end else begin
      mag = {24'b0, ((s && b[7]) ? -b[7:0] : b[7:0])};
      return 18 + $countones(mag);
    end
  endfunction

  // Waits for the chosen instance to be idle, pulses ST for one edge and
  // registers the expected result with the scoreboard.
  task automatic issue(input bit w32, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat);
    int k;
    sb_t e;
    k = 0;
    @(negedge CLK);
    while ((w32 ? busy32 : busy8) && k < 400) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 400) chk(w32 ? "idle_timeout32" : "idle_timeout8", 64'd1, 64'd0);
    if (w32) begin
      st32 = 1'b1; s32 = s; a32 = a; b32 = b;
    end else begin
      st8 = 1'b1; s8 = s; a8 = a[7:0]; b8 = b[7:0];
    end
    @(posedge CLK);
    #1;
    e.prod = exp; e.lat = lat; e.start = cyc;
    if (w32) q32.push_back(e); else q8.push_back(e);
    @(negedge CLK);
    if (w32) st32 = 1'b0; else st8 = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q8.size() != 0 || q32.size() != 0) && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 3000) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // Monitors: sampled on the falling edge, clear of the active edge.
  int busy_n8 = 0, busy_n32 = 0;
  logic prev8 = 1'b0, prev32 = 1'b0;

  always @(negedge CLK) begin
    sb_t e;
    if (RST) begin
      busy_n8 = 0;
      prev8   = 1'b0;
    end else begin
      if (done8) begin
        if (q8.size() == 0) begin
          chk("spurious_done8", 64'd1, 64'd0);
        end else begin
          e = q8.pop_front();
          chk("prod8", {48'b0, prod8}, e.prod);
          chk("lat8", 64'(cyc - e.start), 64'(e.lat));
          chk("busy_len8", 64'(busy_n8), 64'(e.lat));
          chk("busy_fall8", {63'b0, busy8}, 64'd0);
          chk("done_width8", {63'b0, prev8}, 64'd0);
        end
        busy_n8 = 0;
      end else if (busy8) begin
        busy_n8++;
      end
      prev8 = done8;
    end
  end

  always @(negedge CLK) begin
    sb_t e;
    if (RST) begin
      busy_n32 = 0;
      prev32   = 1'b0;
    end else begin
      if (done32) begin
        if (q32.size() == 0) begin
          chk("spurious_done32", 64'd1, 64'd0);
        end else begin
          e = q32.pop_front();
          chk("prod32", prod32, e.prod);
          chk("lat32", 64'(cyc - e.start), 64'(e.lat));
          chk("busy_len32", 64'(busy_n32), 64'(e.lat));
          chk("done_width32", {63'b0, prev32}, 64'd0);
        end
        busy_n32 = 0;
      end else if (busy32) begin
        busy_n32++;
      end
      prev32 = done32;
    end
  end

  vec_t vt[11];
  int   k;
  sb_t  e;
  logic [31:0] ra, rb;
  bit          rs;

  initial begin
    vt[0]  = '{1'b0, 8'd13,  8'd11,  16'h008F, 21};
    vt[1]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, 20};
    vt[2]  = '{1'b1, 8'h80,  8'h80,  16'h4000, 19};
    vt[3]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, 26};
    vt[4]  = '{1'b0, 8'd200, 8'd0,   16'h0000, 18};
    vt[5]  = '{1'b1, 8'h80,  8'h01,  16'hFF80, 19};
    vt[6]  = '{1'b1, 8'h00,  8'h85,  16'h0000, 24};
    vt[7]  = '{1'b1, 8'hFF,  8'h01,  16'hFFFF, 19};
    vt[8]  = '{1'b1, 8'h7F,  8'h7F,  16'h3F01, 25};
    vt[9]  = '{1'b1, 8'h80,  8'hFF,  16'h0080, 19};
    vt[10] = '{1'b0, 8'd7,   8'd6,   16'h002A, 20};

    // Reset state.
    #1;
    chk("rst_busy8",  {63'b0, busy8},  64'd0);
    chk("rst_done8",  {63'b0, done8},  64'd0);
    chk("rst_prod8",  {48'b0, prod8},  64'd0);
    chk("rst_busy32", {63'b0, busy32}, 64'd0);
    chk("rst_prod32", prod32,          64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      issue(1'b0, vt[i].sgn, {24'b0, vt[i].a}, {24'b0, vt[i].b},
            {48'b0, vt[i].prod}, vt[i].lat);
    end
    drain();

    // ST held high with operands changed mid-run; back-to-back at DONE.
    @(negedge CLK);
    st8 = 1'b1; s8 = 1'b0; a8 = 8'd13; b8 = 8'd11;
    @(posedge CLK);
    #1;
    e.prod = 64'h8F; e.lat = 21; e.start = cyc;
    q8.push_back(e);
    repeat (4) @(negedge CLK);
    a8 = 8'd200; b8 = 8'd77;
    @(negedge CLK);
    a8 = 8'd3; b8 = 8'd5;
    k = 0;
    while (!done8 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 100) chk("held_st_timeout", 64'd1, 64'd0);
    @(posedge CLK);
    #1;
    e.prod = 64'h0F; e.lat = 20; e.start = cyc;
    q8.push_back(e);
    @(negedge CLK);
    st8 = 1'b0;
    drain();

    // Reset in the middle of a 13 x 11 run.
    issue(1'b0, 1'b0, 32'd13, 32'd11, 64'h8F, 21);
    repeat (7) @(negedge CLK);
    RST = 1'b1;
    q8.delete();
    #1;
    chk("midrst_busy8", {63'b0, busy8}, 64'd0);
    chk("midrst_prod8", {48'b0, prod8}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    chk("postrst_busy8", {63'b0, busy8}, 64'd0);
    chk("postrst_prod8", {48'b0, prod8}, 64'd0);
    issue(1'b0, 1'b0, 32'd7, 32'd6, 64'h2A, 20);
    drain();

    // Randomised N=8, with corner operands mixed in.
    for (int i = 0; i < 500; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = {24'b0, 8'($urandom)};
      rb = {24'b0, 8'($urandom)};
      if (i % 17 == 0) ra = 32'h80;
      if (i % 19 == 0) rb = 32'hFF;
      issue(1'b0, rs, ra, rb, ref_prod(1'b0, rs, ra, rb), ref_lat(1'b0, rs, rb));
    end
    drain();

    // Randomised N=32.
    for (int i = 0; i < 120; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
      if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
      if (i == 2) begin ra = 32'd0;         rb = 32'hFFFF_FFFF; end
      issue(1'b1, rs, ra, rb, ref_prod(1'b1, rs, ra, rb), ref_lat(1'b1, rs, rb));
    end
    drain();

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
